// File: rtl/div_issue_ctrl.sv
// EXE-stage issue controller for the multi-cycle divider: operand hold, HI/LO
// write-back, flush handling, divide-by-zero bypass and a hang watchdog.
module div_issue_ctrl #(
    parameter bit ZERO_BYPASS = 1'b1,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_signed_i,
    input  logic [31:0] req_x_i,
    input  logic [31:0] req_y_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        div_o,
    output logic        div_signed_o,
    output logic [31:0] div_x_o,
    output logic [31:0] div_y_o,
    input  logic        div_complete_i,
    input  logic [31:0] div_s_i,
    input  logic [31:0] div_r_i,
    output logic        hilo_we_o,
    output logic [31:0] hi_wdata_o,
    output logic [31:0] lo_wdata_o,
    output logic        err_timeout_o
);
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, WRITE, ABORT} state_e;

    state_e          state_q, state_d;
    logic            sgn_q, sgn_d;
    logic [31:0]     x_q, x_d, y_q, y_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic            err_q, err_d;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            sgn_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        x_d     = x_q;
        y_d     = y_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        wd_d    = wd_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                wd_d = '0;
                if (req_valid_i && !flush_i) begin
                    sgn_d = req_signed_i;
                    x_d   = req_x_i;
                    y_d   = req_y_i;
                    if (ZERO_BYPASS && req_y_i == 32'd0) begin
                        // Divide-by-zero result without waking the divider.
                        hi_d    = req_x_i;
                        lo_d    = 32'hFFFF_FFFF;
                        state_d = WRITE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                wd_d = wd_q + 1'b1;
                if (flush_i) begin
                    state_d = ABORT;
                end else if (div_complete_i) begin
                    hi_d    = div_r_i;
                    lo_d    = div_s_i;
                    state_d = WRITE;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ABORT;
                end
            end
            WRITE:   state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign div_o         = (state_q == BUSY);
    assign div_signed_o  = sgn_q;
    assign div_x_o       = x_q;
    assign div_y_o       = y_q;
    // Flush arriving during the write cycle cancels the architectural update.
    assign hilo_we_o     = (state_q == WRITE) && !flush_i;
    assign hi_wdata_o    = hi_q;
    assign lo_wdata_o    = lo_q;
    assign err_timeout_o = err_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: scoreboard of expected HI/LO writes popped
// by a monitor on hilo_we, plus inline protocol/timing checks.
module tb_div_issue_ctrl;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0, req_signed = 1'b0, flush = 1'b0;
    logic [31:0] req_x = '0, req_y = '0;
    logic        div_complete = 1'b0;
    logic [31:0] div_s = '0, div_r = '0;

    logic        req_ready, busy, div, div_signed, hilo_we, err_timeout;
    logic [31:0] div_x, div_y, hi_wdata, lo_wdata;
    logic        req_ready0, busy0, div0, div_signed0, hilo_we0, err_timeout0;
    logic [31:0] div_x0, div_y0, hi_wdata0, lo_wdata0;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    div_issue_ctrl #(.ZERO_BYPASS(1'b1), .TIMEOUT(TO)) dut (
        .clk_i(clk), .resetn_i(resetn), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_signed_i(req_signed), .req_x_i(req_x), .req_y_i(req_y), .flush_i(flush),
        .busy_o(busy), .div_o(div), .div_signed_o(div_signed), .div_x_o(div_x),
        .div_y_o(div_y), .div_complete_i(div_complete), .div_s_i(div_s), .div_r_i(div_r),
        .hilo_we_o(hilo_we), .hi_wdata_o(hi_wdata), .lo_wdata_o(lo_wdata),
        .err_timeout_o(err_timeout));

    div_issue_ctrl #(.ZERO_BYPASS(1'b0), .TIMEOUT(TO)) dut0 (
        .clk_i(clk), .resetn_i(resetn), .req_valid_i(req_valid), .req_ready_o(req_ready0),
        .req_signed_i(req_signed), .req_x_i(req_x), .req_y_i(req_y), .flush_i(flush),
        .busy_o(busy0), .div_o(div0), .div_signed_o(div_signed0), .div_x_o(div_x0),
        .div_y_o(div_y0), .div_complete_i(div_complete), .div_s_i(div_s), .div_r_i(div_r),
        .hilo_we_o(hilo_we0), .hi_wdata_o(hi_wdata0), .lo_wdata_o(lo_wdata0),
        .err_timeout_o(err_timeout0));

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every HI/LO write must match the oldest expected result,
    // and the operands must not move while div is high.
    logic        prev_div = 1'b0;
    logic [64:0] held;
    always @(negedge clk) begin
        if (hilo_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_hilo_we", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("hi_wdata", hi_wdata, e[63:32]);
                chk("lo_wdata", lo_wdata, e[31:0]);
            end
        end
        if (div) begin
            if (!prev_div) held = {div_signed, div_x, div_y};
            else chk("div_operands_stable", {31'd0, held == {div_signed, div_x, div_y}}, 32'd1);
        end
        prev_div = div;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
        int g = 0;
        while (!req_ready && g < 50) begin step(); g++; end
        if (g == 50) chk("ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1; req_signed = s; req_x = x; req_y = y;
        step();
        req_valid = 1'b0;
    endtask

    // Called in BUSY cycle 1; divider completes in BUSY cycle n.
    task automatic complete(input int n, input logic [31:0] s, input logic [31:0] r);
        repeat (n - 1) step();
        chk("div_high_before_complete", {31'd0, div}, 32'd1);
        div_complete = 1'b1; div_s = s; div_r = r;
        step();
        div_complete = 1'b0; div_s = 32'hDEAD_BEEF; div_r = 32'hDEAD_BEEF;
        chk("hilo_we_after_complete", {31'd0, hilo_we}, 32'd1);
        chk("div_drops_after_complete", {31'd0, div}, 32'd0);
        step();
        chk("ready_after_write", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        #12;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy_div_we_err", {28'd0, busy, div, hilo_we, err_timeout}, 32'd0);
        chk("rst_hi", hi_wdata, 32'd0);
        chk("rst_lo", lo_wdata, 32'd0);
        chk("rst_div_x", div_x, 32'd0);
        resetn = 1'b1;
        step();

        // DIVU 100/7
        exp_q.push_back({32'd2, 32'd14});
        issue(1'b0, 32'd100, 32'd7);
        chk("div_latency", {31'd0, div}, 32'd1);
        chk("div_x", div_x, 32'd100);
        chk("div_y", div_y, 32'd7);
        complete(5, 32'd14, 32'd2);

        // DIV -7/2 and DIVU FFFFFFFF/1, back to back
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("div_signed", {31'd0, div_signed}, 32'd1);
        complete(3, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        exp_q.push_back({32'd0, 32'hFFFF_FFFF});
        issue(1'b0, 32'hFFFF_FFFF, 32'd1);
        chk("divu_signed_low", {31'd0, div_signed}, 32'd0);
        complete(1, 32'hFFFF_FFFF, 32'd0);

        // Zero bypass 5/0; the non-bypass instance issues instead
        exp_q.push_back({32'd5, 32'hFFFF_FFFF});
        issue(1'b0, 32'd5, 32'd0);
        chk("bypass_no_div", {31'd0, div}, 32'd0);
        chk("bypass_we_next_cycle", {31'd0, hilo_we}, 32'd1);
        chk("nobypass_div", {31'd0, div0}, 32'd1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("nobypass_idle", {31'd0, req_ready0}, 32'd1);

        // Flush on 10th BUSY cycle
        issue(1'b0, 32'd50, 32'd3);
        repeat (9) step();
        chk("busy_before_flush", {31'd0, div}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("abort_div_low", {31'd0, div}, 32'd0);
        chk("abort_not_ready", {31'd0, req_ready}, 32'd0);
        step();
        chk("ready_after_abort", {31'd0, req_ready}, 32'd1);
        exp_q.push_back({32'd2, 32'd14});
        issue(1'b0, 32'd100, 32'd7);
        complete(2, 32'd14, 32'd2);

        // Watchdog: completion never arrives
        issue(1'b1, 32'd9, 32'd4);
        k = 1;
        while (!err_timeout && k < 200) begin step(); k++; end
        chk("timeout_busy_cycles", 32'(k - 1), 32'(TO));
        chk("timeout_div_low", {31'd0, div}, 32'd0);
        step();
        chk("timeout_pulse_one", {31'd0, err_timeout}, 32'd0);
        chk("timeout_ready", {31'd0, req_ready}, 32'd1);

        // Async reset mid-BUSY
        issue(1'b0, 32'd77, 32'd5);
        step(); step();
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_div", {31'd0, div}, 32'd0);
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        chk("rst_async_ready", {31'd0, req_ready}, 32'd1);
        #2 resetn = 1'b1;
        step();

        // Flush and complete together: flush wins
        issue(1'b0, 32'd20, 32'd6);
        step();
        flush = 1'b1; div_complete = 1'b1; div_s = 32'd3; div_r = 32'd2;
        step();
        flush = 1'b0; div_complete = 1'b0;
        chk("flush_wins_abort", {30'd0, div, req_ready}, 32'd0);
        step();

        // Flush during WRITE suppresses the strobe
        issue(1'b0, 32'd9, 32'd0);
        flush = 1'b1;
        #3;
        chk("write_flush_we", {31'd0, hilo_we}, 32'd0);
        step();
        flush = 1'b0;
        repeat (3) step();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
